// File: rtl/led_scan_sched.sv
// Frame scheduler for an 11-LED charlieplexed RGB array: double-buffered brightness
// levels, three anode phases separated by blanking, per-phase PWM on the cathodes.

module led_scan_lane #(
    parameter int PWM_BITS = 8,
    parameter int MAP      = 0   // colour per phase 0,1,2 -> 0: R,G,B  1: B,G,R  2: G,R,B
) (
    input  logic [2:0][PWM_BITS-1:0] levels,
    input  logic [1:0]               phase,
    input  logic                     on,
    input  logic [PWM_BITS-1:0]      step,
    output logic                     lit
);
    logic [1:0] col;

    always_comb begin
        col = phase;
        case (MAP)
            1:       col = 2'd2 - phase;
            2:       col = (phase == 2'd0) ? 2'd1 : (phase == 2'd1) ? 2'd0 : 2'd2;
            default: col = phase;
        endcase
        if (phase == 2'd3) col = 2'd0;
    end

    assign lit = on && (step < levels[col]);
endmodule

module led_scan_sched #(
    parameter int NLED         = 11,
    parameter int PWM_BITS     = 8,
    parameter int PRESCALE     = 1,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_valid,
    input  logic [3:0]          wr_led,
    input  logic [1:0]          wr_col,
    input  logic [PWM_BITS-1:0] wr_data,
    input  logic                commit_req,
    output logic                commit_pend,
    output logic                commit_done,
    output logic                frame_start,
    output logic [NLED-1:0]     ledc,
    output logic [2:0]          leda
);
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_ON    = 1'b1;

    logic [0:0]          state;
    logic [1:0]          phase;
    logic [BW-1:0]       bcnt;
    logic [PW-1:0]       pcnt;
    logic [PWM_BITS-1:0] step;

    logic [NLED-1:0][2:0][PWM_BITS-1:0] shadow;
    logic [NLED-1:0][2:0][PWM_BITS-1:0] active;
    logic [NLED-1:0]                    lit;

    logic step_tick, last_step, frame_end, swap, on;

    assign on        = (state == ST_ON);
    assign step_tick = (pcnt == PW'(PRESCALE - 1));
    assign last_step = step_tick && (step == '1);
    assign frame_end = on && (phase == 2'd2) && last_step;
    assign swap      = frame_end && (commit_pend || commit_req);

    // Pulses are combinational so they land on the very cycle they describe.
    assign commit_done = swap && !rst;
    assign frame_start = !rst && !on && (phase == 2'd0) && (bcnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_BLANK;
            phase <= 2'd0;
            bcnt  <= '0;
            pcnt  <= '0;
            step  <= '0;
        end else if (!on) begin
            if (bcnt == BW'(BLANK_CYCLES - 1)) begin
                state <= ST_ON;
                bcnt  <= '0;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end else if (step_tick) begin
            pcnt <= '0;
            step <= step + 1'b1;
            if (step == '1) begin
                state <= ST_BLANK;
                phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
            end
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // A write landing on the swap edge goes to shadow only; active takes the old shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow      <= '0;
            active      <= '0;
            commit_pend <= 1'b0;
        end else begin
            if (swap) active <= shadow;
            for (int i = 0; i < NLED; i++)
                for (int c = 0; c < 3; c++)
                    if (wr_valid && wr_led == 4'(i) && wr_col == 2'(c))
                        shadow[i][c] <= wr_data;
            if (swap)
                commit_pend <= 1'b0;
            else if (commit_req)
                commit_pend <= 1'b1;
        end
    end

    for (genvar i = 0; i < NLED; i++) begin : g_lane
        localparam int MAP = (i == 1 || i == 3 || i == 5 || i == 6) ? 1 :
                             (i == 7 || i == 8) ? 2 : 0;
        led_scan_lane #(.PWM_BITS(PWM_BITS), .MAP(MAP)) u_lane (
            .levels (active[i]),
            .phase  (phase),
            .on     (on),
            .step   (step),
            .lit    (lit[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ledc <= '0;
            leda <= 3'b000;
        end else begin
            ledc <= lit;
            leda <= on ? (3'b001 << phase) : 3'b000;
        end
    end
endmodule

// File: tb/tb_led_scan_sched.sv
// Directed frame-level bench for led_scan_sched: per-phase cathode on-time against a
// shadow/active reference, anode walk, blanking gaps, commit timing and mid-frame reset.

module tb_led_scan_sched;
    localparam int NLED = 11;
    localparam int BL   = 16;
    localparam int ONC  = 256;
    localparam int PH   = BL + ONC;
    localparam int FR   = 3 * PH;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic [3:0]  wr_led = '0;
    logic [1:0]  wr_col = '0;
    logic [7:0]  wr_data = '0;
    logic        commit_req = 1'b0;
    logic        commit_pend, commit_done, frame_start;
    logic [10:0] ledc;
    logic [2:0]  leda;

    always #5 clk = ~clk;

    led_scan_sched #(.NLED(NLED), .PWM_BITS(8), .PRESCALE(1), .BLANK_CYCLES(BL)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_led      (wr_led),
        .wr_col      (wr_col),
        .wr_data     (wr_data),
        .commit_req  (commit_req),
        .commit_pend (commit_pend),
        .commit_done (commit_done),
        .frame_start (frame_start),
        .ledc        (ledc),
        .leda        (leda)
    );

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        int t;
        bit commit;
        int led;
        int col;
        int data;
    } op_t;
    op_t ops[$];

    int m_sh[NLED][3];
    int m_act[NLED][3];
    bit m_pend;
    bit after_rst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wiring table: LEDs 1,3,5,6 -> B,G,R; 7,8 -> G,R,B; rest -> R,G,B.
    function automatic int chmap(input int i, input int p);
        case (i)
            1, 3, 5, 6: return 2 - p;
            7, 8:       return (p == 0) ? 1 : (p == 1) ? 0 : 2;
            default:    return p;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NLED; i++)
            for (int c = 0; c < 3; c++) begin
                m_sh[i][c]  = 0;
                m_act[i][c] = 0;
            end
        m_pend    = 1'b0;
        after_rst = 1'b1;
    endtask

    task automatic add_wr(input int t, input int led, input int col, input int data);
        op_t o;
        o.t = t; o.commit = 1'b0; o.led = led; o.col = col; o.data = data;
        ops.push_back(o);
    endtask

    task automatic add_commit(input int t);
        op_t o;
        o.t = t; o.commit = 1'b1; o.led = 0; o.col = 0; o.data = 0;
        ops.push_back(o);
    endtask

    // Entered at posedge+1 of the first BLANK cycle of phase 0; leaves at the next one.
    task automatic run_frame(input string nm);
        int hi[3][NLED];
        int on_cnt[3];
        int act0[NLED][3];
        int zero_cnt, bad, fs_cnt, done_cnt, done_t, exp_done, idx;
        bit creq;
        act0 = m_act;
        exp_done = -1; done_t = -1;
        zero_cnt = 0; bad = 0; fs_cnt = 0; done_cnt = 0;
        for (int p = 0; p < 3; p++) begin
            on_cnt[p] = 0;
            for (int i = 0; i < NLED; i++) hi[p][i] = 0;
        end
        chk({nm, " pend@start"}, 32'(commit_pend), 32'(m_pend));
        for (int t = 0; t < FR; t++) begin
            creq = 1'b0;
            wr_valid = 1'b0;
            commit_req = 1'b0;
            foreach (ops[k]) begin
                if (ops[k].t == t) begin
                    if (ops[k].commit) begin
                        commit_req = 1'b1;
                        creq = 1'b1;
                    end else begin
                        wr_valid = 1'b1;
                        wr_led   = 4'(ops[k].led);
                        wr_col   = 2'(ops[k].col);
                        wr_data  = 8'(ops[k].data);
                    end
                end
            end
            #1;
            if (t == FR - 1 && (m_pend || creq)) begin
                m_act = m_sh;
                m_pend = 1'b0;
                exp_done = t;
            end else if (creq) begin
                m_pend = 1'b1;
            end
            if (wr_valid && wr_led < 4'(NLED) && wr_col < 2'd3)
                m_sh[wr_led][wr_col] = int'(wr_data);

            if (t == 0)  chk({nm, " frame_start@0"}, 32'(frame_start), 32'd1);
            if (t == 16) chk({nm, " leda@16"}, 32'(leda), 32'd0);
            if (t == 17) chk({nm, " leda@17"}, 32'(leda), 32'd1);
            if (t == 289) chk({nm, " leda@289"}, 32'(leda), 32'd2);
            if (t == 561) chk({nm, " leda@561"}, 32'(leda), 32'd4);
            if (frame_start === 1'b1) fs_cnt++;
            if (commit_done === 1'b1) begin
                done_cnt++;
                done_t = t;
            end
            idx = -1;
            case (leda)
                3'b000: begin
                    zero_cnt++;
                    if (ledc !== '0) bad++;
                end
                3'b001: idx = 0;
                3'b010: idx = 1;
                3'b100: idx = 2;
                default: bad++;
            endcase
            if (idx >= 0) begin
                on_cnt[idx]++;
                for (int i = 0; i < NLED; i++)
                    if (ledc[i] === 1'b1) hi[idx][i]++;
            end
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0;
        commit_req = 1'b0;
        chk({nm, " frame_start count"}, 32'(fs_cnt), 32'd1);
        chk({nm, " commit_done cycle"}, 32'(done_t), 32'(exp_done));
        chk({nm, " commit_done count"}, 32'(done_cnt), (exp_done >= 0) ? 32'd1 : 32'd0);
        chk({nm, " leda on p0"}, 32'(on_cnt[0]), 32'(ONC));
        chk({nm, " leda on p1"}, 32'(on_cnt[1]), 32'(ONC));
        chk({nm, " leda on p2"}, 32'(on_cnt[2]), after_rst ? 32'(ONC - 1) : 32'(ONC));
        chk({nm, " blank cycles"}, 32'(zero_cnt), after_rst ? 32'(3 * BL + 1) : 32'(3 * BL));
        chk({nm, " ledc in blank / bad leda"}, 32'(bad), 32'd0);
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < NLED; i++)
                chk($sformatf("%s on-time p%0d led%0d", nm, p, i), 32'(hi[p][i]),
                    32'(act0[i][chmap(i, p)]));
        after_rst = 1'b0;
        ops.delete();
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        chk("reset ledc", 32'(ledc), 32'd0);
        chk("reset leda", 32'(leda), 32'd0);
        chk("reset commit_pend", 32'(commit_pend), 32'd0);
        chk("reset commit_done", 32'(commit_done), 32'd0);
        chk("reset frame_start", 32'(frame_start), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // f0: dark frame; LED0 R=64 committed at cycle 10, swapped at frame end
        add_wr(1, 0, 0, 64);
        add_commit(10);
        run_frame("f0");

        // f1: LED0 lit 64 clks in phase 0; stage LED7 G=255, LED1 B=1, clear LED0
        add_wr(3, 7, 1, 255);
        add_wr(4, 1, 2, 1);
        add_wr(5, 0, 0, 0);
        add_commit(20);
        run_frame("f1");

        // f2..f4: uncommitted mid-frame write must not show
        add_wr(100, 2, 1, 100);
        run_frame("f2");
        run_frame("f3");

        // f4: ignored writes, then commit and a write both on the frame-end cycle
        add_wr(1, 11, 0, 255);
        add_wr(2, 3, 3, 255);
        add_commit(FR - 1);
        add_wr(FR - 1, 9, 2, 50);
        run_frame("f4");

        // f5: LED2 G shows; LED9 B still only in shadow; re-request while pending
        add_commit(5);
        add_commit(6);
        run_frame("f5");

        run_frame("f6");

        // reset during phase 1 ON with a commit pending
        for (int t = 0; t <= 400; t++) begin
            commit_req = (t == 0);
            #1;
            if (t == 400) begin
                chk("pre-reset commit_pend", 32'(commit_pend), 32'd1);
                chk("pre-reset leda", 32'(leda), 32'd2);
                rst = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        commit_req = 1'b0;
        @(posedge clk); #1;
        chk("mid reset ledc", 32'(ledc), 32'd0);
        chk("mid reset leda", 32'(leda), 32'd0);
        chk("mid reset commit_pend", 32'(commit_pend), 32'd0);
        chk("mid reset commit_done", 32'(commit_done), 32'd0);
        rst = 1'b0;
        model_reset();
        run_frame("f7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
